// File: rtl/skolem_sweep_checker.sv
// Exhaustive sweep checker for a combinational/pipelined Skolem-function block against a parity spec.
// Build option: define SKF_STOP_ON_FAIL_EN to end the sweep early on the first violation.
module skolem_sweep_checker #(
    parameter int N_X      = 6,
    parameter int N_Y      = 2,
    parameter int DUT_LAT  = 0,
    parameter bit SPEC_PAR = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    output logic [N_X-1:0] x_out,
    input  logic [N_Y-1:0] y_in,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [N_X:0]   fail_cnt,
    output logic [N_X-1:0] first_fail
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [N_X-1:0] X_LAST = '1;
    localparam int             DW     = $clog2(DUT_LAT + 2);

    state_t          state;
    logic [DW-1:0]   drain_cnt;
    logic            issue;
    logic            chk_valid;
    logic [N_X-1:0]  chk_x;
    logic            violation;
    logic            stop_issue;
    logic [N_X:0]    fail_nxt;

    assign issue = (state == RUN);

    // The check for an issued x happens when the block's answer for it is due on y_in.
    generate
        if (DUT_LAT == 0) begin : g_comb
            assign chk_valid = issue;
            assign chk_x     = x_out;
        end else begin : g_pipe
            logic [DUT_LAT-1:0] vld_q;
            logic [N_X-1:0]     x_q [DUT_LAT];

            // NOTE: this is a short shift register, not a RAM, so resetting every stage is cheap
            // and guarantees no stale valid bit survives an abandoned sweep.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= '0;
                    for (int i = 0; i < DUT_LAT; i++) x_q[i] <= '0;
                end else begin
                    vld_q[0] <= issue;
                    x_q[0]   <= x_out;
                    for (int i = 1; i < DUT_LAT; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        x_q[i]   <= x_q[i-1];
                    end
                end
            end

            assign chk_valid = vld_q[DUT_LAT-1];
            assign chk_x     = x_q[DUT_LAT-1];
        end
    endgenerate

    assign violation = chk_valid && (((^chk_x) ^ (^y_in)) != SPEC_PAR);
    assign fail_nxt  = fail_cnt + (N_X+1)'(violation);

`ifdef SKF_STOP_ON_FAIL_EN
    assign stop_issue = violation;
`else
    assign stop_issue = 1'b0;
`endif

    // NOTE: all state and registered outputs use non-blocking assignments so every read in this
    // block sees the pre-edge value; later assignments in the same edge simply override earlier ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            x_out      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_cnt   <= '0;
            first_fail <= '0;
            drain_cnt  <= '0;
        end else begin
            done <= 1'b0;
            if (violation) begin
                fail_cnt <= fail_nxt;
                if (fail_cnt == '0) first_fail <= chk_x;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RUN;
                        x_out      <= '0;
                        busy       <= 1'b1;
                        pass       <= 1'b0;
                        fail_cnt   <= '0;
                        first_fail <= '0;
                    end
                end
                RUN: begin
                    if (x_out == X_LAST || stop_issue) begin
                        if (DUT_LAT == 0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (fail_nxt == '0);
                        end else begin
                            state     <= DRAIN;
                            drain_cnt <= DW'(DUT_LAT - 1);
                        end
                    end else begin
                        x_out <= x_out + N_X'(1);
                    end
                end
                DRAIN: begin
                    // x_out holds here so a misaligned wrapper still sees a stable final input.
                    if (drain_cnt == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (fail_nxt == '0);
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_skolem_sweep_checker.sv
// Directed bench for skolem_sweep_checker: a DUT_LAT=0 instance driven by a selectable fault model
// and a DUT_LAT=2 instance fed through two (or, misaligned, one) register stages.
module tb_skolem_sweep_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start0, start1;
    logic [5:0] x0, x1, ff0, ff1;
    logic [1:0] y0, y1;
    logic       busy0, busy1, done0, done1, pass0, pass1;
    logic [6:0] fcnt0, fcnt1;

    int   mode;
    bit   misalign;
    bit   sel;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    skolem_sweep_checker u_lat0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .x_out(x0), .y_in(y0),
        .busy(busy0), .done(done0), .pass(pass0), .fail_cnt(fcnt0), .first_fail(ff0)
    );

    skolem_sweep_checker #(.DUT_LAT(2)) u_lat2 (
        .clk(clk), .rst_n(rst_n), .start(start1), .x_out(x1), .y_in(y1),
        .busy(busy1), .done(done1), .pass(pass1), .fail_cnt(fcnt1), .first_fail(ff1)
    );

    // Reference block: the single y that makes ^{x,y} odd.
    function automatic logic [1:0] good_y(input logic [5:0] x);
        return {1'b0, ~(^x)};
    endfunction

    always_comb begin
        y0 = good_y(x0);
        case (mode)
            1: y0 = 2'b00;
            2: if (x0 == 6'd37) y0 = y0 ^ 2'b01;
            3: if (x0[5])       y0 = y0 ^ 2'b10;
            4: if (x0 == 6'd63) y0 = y0 ^ 2'b01;
            5: if (x0 == 6'd0)  y0 = y0 ^ 2'b01;
            default: ;
        endcase
    end

    logic [1:0] r1, r2;
    always @(posedge clk) begin
        r1 <= good_y(x1);
        r2 <= r1;
    end
    assign y1 = misalign ? r1 : r2;

    logic [5:0] m_x, m_ff;
    logic [6:0] m_fcnt;
    logic [1:0] m_y;
    logic       m_busy, m_done, m_pass;
    assign m_x    = sel ? x1    : x0;
    assign m_ff   = sel ? ff1   : ff0;
    assign m_fcnt = sel ? fcnt1 : fcnt0;
    assign m_y    = sel ? y1    : y0;
    assign m_busy = sel ? busy1 : busy0;
    assign m_done = sel ? done1 : done0;
    assign m_pass = sel ? pass1 : pass0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) start1 = v;
        else     start0 = v;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_x"},     32'(m_x),    0);
        check({tag, "_busy"},  32'(m_busy), 0);
        check({tag, "_done"},  32'(m_done), 0);
        check({tag, "_pass"},  32'(m_pass), 0);
        check({tag, "_fcnt"},  32'(m_fcnt), 0);
        check({tag, "_first"}, 32'(m_ff),   0);
    endtask

    // Entered at the negedge of the first RUN cycle (n=1); returns at the negedge of the done cycle.
    task automatic wait_done(input int pulse_at, input bit hold,
                             output int lat, output int bcyc, output int xz);
        lat = -1; bcyc = 0; xz = 0;
        for (int n = 1; n <= 300; n++) begin
            if (m_busy === 1'b1) bcyc++;
            if (m_busy === 1'b1 && $isunknown(m_y)) xz++;
            if (pulse_at != 0 && n == pulse_at)     set_start(1'b1);
            if (pulse_at != 0 && n == pulse_at + 1) set_start(1'b0);
            if (m_done === 1'b1) begin
                lat = n;
                if (hold) set_start(1'b1);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic launch(input string tag, input int pulse_at, input bit hold,
                          output int lat, output int bcyc, output int xz);
        @(negedge clk);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        check({tag, "_x_first"}, 32'(m_x), 0);
        wait_done(pulse_at, hold, lat, bcyc, xz);
    endtask

    typedef struct {
        string name;
        int    mode;
        int    lat;
        int    fails;
        int    first;
        int    pass;
        int    xlast;
    } vec_t;

    vec_t vecs[6];

    task automatic sweep_check(input vec_t v, input bit s);
        int lat, bcyc, xz;
        sel  = s;
        mode = v.mode;
        launch(v.name, 0, 1'b0, lat, bcyc, xz);
        check({v.name, "_done_cycle"}, lat,          v.lat);
        check({v.name, "_busy_cycles"}, bcyc,        v.lat - 1);
        check({v.name, "_y_no_xz"},    xz,           0);
        check({v.name, "_fail_cnt"},   32'(m_fcnt),  v.fails);
        check({v.name, "_first_fail"}, 32'(m_ff),    v.first);
        check({v.name, "_pass"},       32'(m_pass),  v.pass);
        check({v.name, "_x_last"},     32'(m_x),     v.xlast);
        @(negedge clk);
        check({v.name, "_done_1cyc"},  32'(m_done),  0);
        check({v.name, "_busy_after"}, 32'(m_busy),  0);
        check({v.name, "_pass_hold"},  32'(m_pass),  v.pass);
    endtask

    initial begin
        int lat, bcyc, xz, done_seen, busy_seen;
        vec_t v;

`ifdef SKF_STOP_ON_FAIL_EN
        vecs[0] = '{"good",      0, 65,  0,  0, 1, 63};
        vecs[1] = '{"y_zero",    1,  2,  1,  0, 0,  0};
        vecs[2] = '{"flip_37",   2, 39,  1, 37, 0, 37};
        vecs[3] = '{"flip_hi",   3, 34,  1, 32, 0, 32};
        vecs[4] = '{"flip_63",   4, 65,  1, 63, 0, 63};
        vecs[5] = '{"flip_0",    5,  2,  1,  0, 0,  0};
`else
        vecs[0] = '{"good",      0, 65,  0,  0, 1, 63};
        vecs[1] = '{"y_zero",    1, 65, 32,  0, 0, 63};
        vecs[2] = '{"flip_37",   2, 65,  1, 37, 0, 63};
        vecs[3] = '{"flip_hi",   3, 65, 32, 32, 0, 63};
        vecs[4] = '{"flip_63",   4, 65,  1, 63, 0, 63};
        vecs[5] = '{"flip_0",    5, 65,  1,  0, 0, 63};
`endif

        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
        mode = 0; misalign = 1'b0; sel = 1'b0;
        #12;
        check_idle("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("post_reset_l0");
        sel = 1'b1;
        check_idle("post_reset_l2");

        for (int i = 0; i < 6; i++) sweep_check(vecs[i], 1'b0);

        // Two-stage wrapper, aligned and then one stage short.
        v = '{"lat2_good", 0, 67, 0, 0, 1, 63};
        misalign = 1'b0;
        sweep_check(v, 1'b1);
        misalign = 1'b1;
        launch("lat2_mis", 0, 1'b0, lat, bcyc, xz);
        check("lat2_mis_done_seen", 32'(lat > 0), 1);
        check("lat2_mis_nonzero",   32'(m_fcnt != 0), 1);
        check("lat2_mis_first",     32'(m_ff), 0);
        check("lat2_mis_pass",      32'(m_pass), 0);
`ifndef SKF_STOP_ON_FAIL_EN
        check("lat2_mis_fail_cnt",  32'(m_fcnt), 42);
`endif
        misalign = 1'b0;

        // Reset in the middle of a sweep: outputs clear at once and no done follows.
        sel = 1'b0; mode = 0;
        @(negedge clk);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        for (int n = 0; n < 100 && x0 != 6'd20; n++) @(negedge clk);
        check("rst_reached_v20", 32'(x0), 20);
        #2 rst_n = 1'b0;
        #1 check_idle("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0; busy_seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (done0 !== 1'b0) done_seen++;
            if (busy0 !== 1'b0) busy_seen++;
        end
        check("rst_no_done", done_seen, 0);
        check("rst_no_busy", busy_seen, 0);
        sweep_check(vecs[0], 1'b0);

        // start pulsed mid-RUN is ignored; start held across DONE relaunches after one IDLE cycle.
        sel = 1'b0; mode = 3;
        launch("held", 10, 1'b1, lat, bcyc, xz);
        check("held_first_lat",  lat,         vecs[3].lat);
        check("held_first_fcnt", 32'(fcnt0),  vecs[3].fails);
        @(negedge clk);
        check("held_gap_busy",   32'(busy0), 0);
        check("held_gap_done",   32'(done0), 0);
        check("held_gap_x",      32'(x0),    vecs[3].xlast);
        mode = 0;
        @(negedge clk);
        set_start(1'b0);
        check("relaunch_busy",   32'(busy0), 1);
        check("relaunch_x",      32'(x0),    0);
        check("relaunch_fcnt",   32'(fcnt0), 0);
        check("relaunch_first",  32'(ff0),   0);
        check("relaunch_pass",   32'(pass0), 0);
        wait_done(0, 1'b0, lat, bcyc, xz);
        check("relaunch_lat",    lat,         65);
        check("relaunch_pass_end", 32'(pass0), 1);
        check("relaunch_fcnt_end", 32'(fcnt0), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
